execute: RTL and testbench
==========================

Name: execute

Overview:
- Execute stage of the Y86-64 sequential (SEQ) processor.
- Computes valE through a 64-bit ALU selected by icode/ifun.
- Evaluates the branch/move condition Cnd from the incoming condition codes.
- Holds the architectural condition-code (CC) register, updated only by OPq.
- Sits between decode (valA/valB/valC) and memory/write-back.

Parameters:
- None. Data width fixed at 64; icode/ifun fixed at 4 bits.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- icode  input  4  instruction code
- ifun  input  4  function code
- valA  input  64  signed operand A from decode
- valB  input  64  signed operand B from decode
- valC  input  64  signed immediate/displacement
- zf_in  input  1  current ZF, used for Cnd
- sf_in  input  1  current SF, used for Cnd
- of_in  input  1  current OF, used for Cnd
- valE  output  64  signed ALU result, combinational
- Cnd  output  1  condition result, combinational
- zf_out  output  1  registered ZF
- sf_out  output  1  registered SF
- of_out  output  1  registered OF

Behaviour:
- valE is combinational with zero latency; it is not affected by rst.
- valE by icode:
  - 0 halt / 1 nop: 0
  - 2 rrmovq/cmovXX: valA
  - 3 irmovq: valC
  - 4 rmmovq / 5 mrmovq: valB+valC
  - 6 OPq: ALU result
  - 7 jXX: 0
  - 8 call / A pushq: valB-8
  - 9 ret / B popq: valB+8
  - C-F: 0
- OPq ALU by ifun:
  - 0: valB+valA
  - 1: valB-valA
  - 2: valB&valA
  - 3: valB^valA
  - 4-F: valE=0, no CC update
- All arithmetic wraps modulo 2^64.
- Flag computation for OPq, from result r:
  - ZF = (r==0)
  - SF = r[63]
  - OF (add) = (A[63]==B[63]) && (r[63]!=A[63])
  - OF (sub) = (A[63]!=B[63]) && (r[63]!=B[63])
  - OF (and/xor) = 0
- CC register update:
  - On the rising edge with rst=1: zf_out=sf_out=of_out=0. Reset has priority over everything.
  - Else, if icode==6 and ifun<=3: load the computed flags.
  - Otherwise: hold.
  - New flags therefore appear one cycle after the OPq is presented.
- Cnd, only for icode 2 and 7 (0 for all other icodes). Uses zf_in/sf_in/of_in:
  - ifun 0: 1
  - ifun 1 (le): (sf^of)|zf
  - ifun 2 (l): sf^of
  - ifun 3 (e): zf
  - ifun 4 (ne): !zf
  - ifun 5 (ge): !(sf^of)
  - ifun 6 (g): !(sf^of)&!zf
  - ifun 7-F: 0
- Inputs may change every cycle. No handshake and no internal state other than the CC register.

Optional Feature:
- Macro EXECUTE_CC_INTERNAL_EN.
- Defined: Cnd is evaluated from the internal registered flags (zf_out/sf_out/of_out). zf_in/sf_in/of_in are ignored.
- Undefined (default): Cnd uses zf_in/sf_in/of_in as specified above.
- valE and CC update behaviour are identical in both builds.

Test Plan:
- OPq, valA=5, valB=10:
  - ifun0 -> valE=15, next edge ZF/SF/OF=0/0/0
  - ifun1 -> valE=5
  - ifun2 -> valE=0, ZF=1
  - ifun3 -> valE=15
- icode=7, valA=5, valB=10:
  - ifun1 with z/s/o=0/0/0 -> Cnd=0
  - ifun2 with 0/1/0 -> Cnd=1
  - ifun3 with 0/0/1 -> Cnd=0
  - ifun4 with 0/1/1 -> Cnd=1
  - ifun5 with 1/0/0 -> Cnd=1
  - ifun6 with 1/1/0 -> Cnd=0
- Overflow: icode6 ifun0, valA=valB=0x7FFFFFFFFFFFFFFF -> valE=0xFFFFFFFFFFFFFFFE, next edge SF=1, OF=1, ZF=0.
- Address ops, valB=10, valC=25:
  - icode4 -> valE=35
  - icodeA -> valE=2
  - icode9 -> valE=18
  - icode3 -> valE=25
  - icode2 with valA=5, ifun0 -> valE=5, Cnd=1
- Reset: first set flags via OPq 5-5 (ZF=1). Then hold rst=1 one edge with icode6 ifun0 -> all flags 0. Then icode7 (non-OPq) for several edges -> flags hold.

Source files
------------

// File: rtl/execute.sv
// Y86-64 SEQ execute stage: 64-bit ALU producing valE, branch/move condition Cnd, and the CC register.
// Optional macro EXECUTE_CC_INTERNAL_EN: Cnd is evaluated from the registered flags instead of zf_in/sf_in/of_in.
module execute (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  icode,
   input  logic [3:0]  ifun,
   input  logic [63:0] valA,
   input  logic [63:0] valB,
   input  logic [63:0] valC,
   input  logic        zf_in,
   input  logic        sf_in,
   input  logic        of_in,
   output logic [63:0] valE,
   output logic        Cnd,
   output logic        zf_out,
   output logic        sf_out,
   output logic        of_out
);

   logic [63:0] op_res;
   logic        op_zf;
   logic        op_sf;
   logic        op_of;
   logic        op_valid;
   logic        cc_zf;
   logic        cc_sf;
   logic        cc_of;
   logic        sxo;
   logic        cond;

   always_comb begin
      op_res   = '0;
      op_of    = 1'b0;
      op_valid = 1'b1;
      case (ifun)
         4'h0: begin
            op_res = valB + valA;
            op_of  = (valA[63] == valB[63]) && (op_res[63] != valA[63]);
         end
         4'h1: begin
            op_res = valB - valA;
            op_of  = (valA[63] != valB[63]) && (op_res[63] != valB[63]);
         end
         4'h2:    op_res = valB & valA;
         4'h3:    op_res = valB ^ valA;
         default: op_valid = 1'b0;
      endcase
      op_zf = (op_res == 64'd0);
      op_sf = op_res[63];
   end

   always_comb begin
      valE = '0;
      case (icode)
         4'h2:       valE = valA;
         4'h3:       valE = valC;
         4'h4, 4'h5: valE = valB + valC;
         4'h6:       valE = op_res;
         4'h8, 4'hA: valE = valB - 64'd8;
         4'h9, 4'hB: valE = valB + 64'd8;
         default:    valE = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         zf_out <= 1'b0;
         sf_out <= 1'b0;
         of_out <= 1'b0;
      end else if (icode == 4'h6 && op_valid) begin
         zf_out <= op_zf;
         sf_out <= op_sf;
         of_out <= op_of;
      end
   end

`ifdef EXECUTE_CC_INTERNAL_EN
   assign cc_zf = zf_out;
   assign cc_sf = sf_out;
   assign cc_of = of_out;
`else
   assign cc_zf = zf_in;
   assign cc_sf = sf_in;
   assign cc_of = of_in;
`endif

   assign sxo = cc_sf ^ cc_of;

   always_comb begin
      cond = 1'b0;
      case (ifun)
         4'h0:    cond = 1'b1;
         4'h1:    cond = sxo | cc_zf;
         4'h2:    cond = sxo;
         4'h3:    cond = cc_zf;
         4'h4:    cond = !cc_zf;
         4'h5:    cond = !sxo;
         4'h6:    cond = !sxo && !cc_zf;
         default: cond = 1'b0;
      endcase
      // Only cmovXX and jXX carry a condition.
      Cnd = (icode == 4'h2 || icode == 4'h7) ? cond : 1'b0;
   end

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the execute stage (default build: Cnd from zf_in/sf_in/of_in).
module tb_execute;

   logic        clk;
   logic        rst;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [63:0] valA;
   logic [63:0] valB;
   logic [63:0] valC;
   logic        zf_in;
   logic        sf_in;
   logic        of_in;
   logic [63:0] valE;
   logic        Cnd;
   logic        zf_out;
   logic        sf_out;
   logic        of_out;

   int checks;
   int errors;

   execute dut (
      .clk    (clk),
      .rst    (rst),
      .icode  (icode),
      .ifun   (ifun),
      .valA   (valA),
      .valB   (valB),
      .valC   (valC),
      .zf_in  (zf_in),
      .sf_in  (sf_in),
      .of_in  (of_in),
      .valE   (valE),
      .Cnd    (Cnd),
      .zf_out (zf_out),
      .sf_out (sf_out),
      .of_out (of_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge, combinational outputs settle 1 time unit later.
   task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] c, input logic [2:0] zso);
      @(negedge clk);
      icode = ic;
      ifun  = fn;
      valA  = a;
      valB  = b;
      valC  = c;
      {zf_in, sf_in, of_in} = zso;
      #1;
   endtask

   task automatic edge_settle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(4'h3, 4'h0, 64'd0, 64'd0, 64'd77, 3'b000);
      checks++;
      if (valE !== 64'd77) begin
         errors++;
         $display("FAIL reset_valE got %0d expected 77", valE);
      end
      edge_settle();
      checks++;
      if ({zf_out, sf_out, of_out} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags got %b expected 000", {zf_out, sf_out, of_out});
      end
      rst = 1'b0;
   endtask

   task automatic test_opq();
      logic [63:0] exp_e [0:3];
      logic [2:0]  exp_f [0:3];
      exp_e = '{64'd15, 64'd5, 64'd0, 64'd15};
      exp_f = '{3'b000, 3'b000, 3'b100, 3'b000};
      for (int i = 0; i < 4; i++) begin
         drive(4'h6, 4'(i), 64'd5, 64'd10, 64'd0, 3'b000);
         checks++;
         if (valE !== exp_e[i]) begin
            errors++;
            $display("FAIL opq_valE ifun %0d got %0d expected %0d", i, valE, exp_e[i]);
         end
         edge_settle();
         checks++;
         if ({zf_out, sf_out, of_out} !== exp_f[i]) begin
            errors++;
            $display("FAIL opq_flags ifun %0d got %b expected %b", i,
                     {zf_out, sf_out, of_out}, exp_f[i]);
         end
      end
      // Make ZF=1, then an undefined ifun must give 0 and leave flags alone.
      drive(4'h6, 4'h2, 64'd5, 64'd10, 64'd0, 3'b000);
      edge_settle();
      drive(4'h6, 4'h5, 64'd5, 64'd10, 64'd0, 3'b000);
      checks++;
      if (valE !== 64'd0) begin
         errors++;
         $display("FAIL opq_bad_ifun_valE got %0d expected 0", valE);
      end
      edge_settle();
      checks++;
      if ({zf_out, sf_out, of_out} !== 3'b100) begin
         errors++;
         $display("FAIL opq_bad_ifun_hold got %b expected 100", {zf_out, sf_out, of_out});
      end
   endtask

   task automatic test_overflow();
      drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 3'b000);
      checks++;
      if (valE !== 64'hFFFF_FFFF_FFFF_FFFE) begin
         errors++;
         $display("FAIL add_ovf_valE got %h expected fffffffffffffffe", valE);
      end
      edge_settle();
      checks++;
      if ({zf_out, sf_out, of_out} !== 3'b011) begin
         errors++;
         $display("FAIL add_ovf_flags got %b expected 011", {zf_out, sf_out, of_out});
      end
      // 0x8000...0 - 1 = 0x7FFF...F: sign flips away from valB.
      drive(4'h6, 4'h1, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 3'b000);
      checks++;
      if (valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL sub_ovf_valE got %h expected 7fffffffffffffff", valE);
      end
      edge_settle();
      checks++;
      if ({zf_out, sf_out, of_out} !== 3'b001) begin
         errors++;
         $display("FAIL sub_ovf_flags got %b expected 001", {zf_out, sf_out, of_out});
      end
   endtask

   task automatic test_cond();
      logic [2:0] zso [0:7];
      logic       exp_c [0:7];
      logic [2:0] held;
      zso   = '{3'b000, 3'b000, 3'b010, 3'b001, 3'b011, 3'b100, 3'b110, 3'b111};
      exp_c = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      held  = {zf_out, sf_out, of_out};
      for (int i = 0; i < 8; i++) begin
         drive(4'h7, 4'(i), 64'd5, 64'd10, 64'd0, zso[i]);
         checks++;
         if (Cnd !== exp_c[i] || valE !== 64'd0) begin
            errors++;
            $display("FAIL jxx_cnd ifun %0d got Cnd=%b valE=%0d expected Cnd=%b valE=0", i, Cnd,
                     valE, exp_c[i]);
         end
         edge_settle();
      end
      checks++;
      if ({zf_out, sf_out, of_out} !== held) begin
         errors++;
         $display("FAIL jxx_flag_hold got %b expected %b", {zf_out, sf_out, of_out}, held);
      end
      // Non-conditional icode with a condition that would otherwise be true.
      drive(4'h4, 4'h0, 64'd5, 64'd10, 64'd25, 3'b000);
      checks++;
      if (Cnd !== 1'b0) begin
         errors++;
         $display("FAIL cnd_other_icode got %b expected 0", Cnd);
      end
   endtask

   task automatic test_addr();
      logic [3:0]  ic [0:10];
      logic [63:0] exp_e [0:10];
      ic    = '{4'h4, 4'h5, 4'hA, 4'h8, 4'h9, 4'hB, 4'h3, 4'h0, 4'h1, 4'h7, 4'hC};
      exp_e = '{64'd35, 64'd35, 64'd2, 64'd2, 64'd18, 64'd18, 64'd25, 64'd0, 64'd0, 64'd0, 64'd0};
      for (int i = 0; i < 11; i++) begin
         drive(ic[i], 4'h0, 64'd5, 64'd10, 64'd25, 3'b000);
         checks++;
         if (valE !== exp_e[i]) begin
            errors++;
            $display("FAIL addr_valE icode %h got %0d expected %0d", ic[i], valE, exp_e[i]);
         end
      end
      drive(4'h2, 4'h0, 64'd5, 64'd10, 64'd25, 3'b000);
      checks++;
      if (valE !== 64'd5 || Cnd !== 1'b1) begin
         errors++;
         $display("FAIL rrmovq got valE=%0d Cnd=%b expected valE=5 Cnd=1", valE, Cnd);
      end
   endtask

   task automatic test_reset_priority();
      drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 3'b000);
      edge_settle();
      checks++;
      if ({zf_out, sf_out, of_out} !== 3'b100) begin
         errors++;
         $display("FAIL sub_zero_flags got %b expected 100", {zf_out, sf_out, of_out});
      end
      drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 3'b000);
      rst = 1'b1;
      edge_settle();
      rst = 1'b0;
      checks++;
      if ({zf_out, sf_out, of_out} !== 3'b000) begin
         errors++;
         $display("FAIL reset_priority got %b expected 000", {zf_out, sf_out, of_out});
      end
      for (int i = 0; i < 3; i++) begin
         drive(4'h7, 4'(i), 64'd5, 64'd5, 64'd0, 3'b111);
         edge_settle();
      end
      checks++;
      if ({zf_out, sf_out, of_out} !== 3'b000) begin
         errors++;
         $display("FAIL post_reset_hold got %b expected 000", {zf_out, sf_out, of_out});
      end
   endtask

   task automatic test_back_to_back();
      // Flags follow each OPq one edge later, with no gap between instructions.
      drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 3'b000);
      edge_settle();
      checks++;
      if ({zf_out, sf_out, of_out} !== 3'b100) begin
         errors++;
         $display("FAIL b2b_first got %b expected 100", {zf_out, sf_out, of_out});
      end
      drive(4'h6, 4'h1, 64'd10, 64'd5, 64'd0, 3'b000);
      checks++;
      if (valE !== 64'hFFFF_FFFF_FFFF_FFFB) begin
         errors++;
         $display("FAIL b2b_valE got %h expected fffffffffffffffb", valE);
      end
      edge_settle();
      checks++;
      if ({zf_out, sf_out, of_out} !== 3'b010) begin
         errors++;
         $display("FAIL b2b_second got %b expected 010", {zf_out, sf_out, of_out});
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      icode  = '0;
      ifun   = '0;
      valA   = '0;
      valB   = '0;
      valC   = '0;
      zf_in  = 1'b0;
      sf_in  = 1'b0;
      of_in  = 1'b0;
      test_reset();
      test_opq();
      test_overflow();
      test_cond();
      test_addr();
      test_reset_priority();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
